// File: rtl/vector_element_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : vector_element_streamer_if
// Description : Load/stream bundle for vector_element_streamer.
//               slave  = streamer view (accepts loads, drives the stream)
//               master = producer/consumer view
//   load_valid/load_ready/load_vec/start_idx/count : load request channel
//   stride (VES_STRIDE_EN only)                     : per-run index step
//   out_valid/out_ready/out_data/out_idx/out_last   : element stream
//   busy/err                                        : status
// Optional    : VES_STRIDE_EN adds the stride signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface vector_element_streamer_if #(
    parameter int N_ELEM = 8,
    parameter int NBITS  = 32,
    parameter int IDX_W  = 3
);
    logic                    load_valid;
    logic                    load_ready;
    logic [N_ELEM*NBITS-1:0] load_vec;
    logic [IDX_W-1:0]        start_idx;
    logic [IDX_W:0]          count;
`ifdef VES_STRIDE_EN
    logic [IDX_W-1:0]        stride;
`endif
    logic                    out_valid;
    logic                    out_ready;
    logic [NBITS-1:0]        out_data;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_last;
    logic                    busy;
    logic                    err;

`ifdef VES_STRIDE_EN
    modport slave (
        input  load_valid, load_vec, start_idx, count, stride, out_ready,
        output load_ready, out_valid, out_data, out_idx, out_last, busy, err
    );
    modport master (
        output load_valid, load_vec, start_idx, count, stride, out_ready,
        input  load_ready, out_valid, out_data, out_idx, out_last, busy, err
    );
`else
    modport slave (
        input  load_valid, load_vec, start_idx, count, out_ready,
        output load_ready, out_valid, out_data, out_idx, out_last, busy, err
    );
    modport master (
        output load_valid, load_vec, start_idx, count, out_ready,
        input  load_ready, out_valid, out_data, out_idx, out_last, busy, err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/vector_element_streamer.sv
`default_nettype none
// ============================================================================
// Module      : vector_element_streamer
// Description : Captures a packed vector of N_ELEM elements and streams
//               `count` of them over valid/ready, starting at start_idx and
//               wrapping modulo N_ELEM. Element 0 sits in the MSBs of load_vec.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - vector_element_streamer_if.slave (load channel,
//                        output stream, busy/err status)
// Optional    : VES_STRIDE_EN - index advances by a per-run stride instead
//               of 1; a stride >= N_ELEM is rejected like a bad load.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_element_streamer #(
    parameter int N_ELEM = 8,
    parameter int NBITS  = 32,
    parameter int IDX_W  = 3
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    vector_element_streamer_if.slave  bus
);
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // N_ELEM held in IDX_W+1 bits so it is representable even when
    // N_ELEM == 2**IDX_W.
    localparam logic [IDX_W:0] C_N_ELEM = (IDX_W+1)'(N_ELEM);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [N_ELEM*NBITS-1:0] r_vec;
    logic [IDX_W:0]          r_rem;
    logic [NBITS-1:0]        r_out_data;
    logic [IDX_W-1:0]        r_out_idx;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic                    r_load_ready;
    logic                    r_err;

    logic                    w_load_fire;
    logic                    w_load_bad;
    logic                    w_beat_fire;
    logic [IDX_W-1:0]        w_step;
    logic [IDX_W:0]          w_idx_sum;
    logic [IDX_W-1:0]        w_idx_next;

    // Element i lives at bits [(N_ELEM-i)*NBITS-1 -: NBITS].
    function automatic logic [NBITS-1:0] f_elem(
        input logic [N_ELEM*NBITS-1:0] vec,
        input logic [IDX_W-1:0]        idx
    );
        logic [NBITS-1:0] sel;
        sel = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (idx == IDX_W'(i)) begin
                sel = vec[(N_ELEM-i)*NBITS-1 -: NBITS];
            end
        end
        return sel;
    endfunction

`ifdef VES_STRIDE_EN
    logic [IDX_W-1:0] r_stride;

    assign w_step     = r_stride;
    assign w_load_bad = (bus.count == '0) || (bus.count > C_N_ELEM) ||
                        ({1'b0, bus.start_idx} >= C_N_ELEM) ||
                        ({1'b0, bus.stride} >= C_N_ELEM);
`else
    assign w_step     = IDX_W'(1);
    assign w_load_bad = (bus.count == '0) || (bus.count > C_N_ELEM) ||
                        ({1'b0, bus.start_idx} >= C_N_ELEM);
`endif

    assign w_load_fire = (r_state == S_IDLE) && r_load_ready && bus.load_valid;
    assign w_beat_fire = r_out_valid && bus.out_ready;

    // Both operands are < N_ELEM, so one conditional subtract wraps the sum.
    assign w_idx_sum  = {1'b0, r_out_idx} + {1'b0, w_step};
    assign w_idx_next = (w_idx_sum >= C_N_ELEM) ? IDX_W'(w_idx_sum - C_N_ELEM)
                                                : w_idx_sum[IDX_W-1:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load_fire && !w_load_bad) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_beat_fire && r_out_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_vec        <= '0;
            r_rem        <= '0;
            r_out_data   <= '0;
            r_out_idx    <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_load_ready <= 1'b0;
            r_err        <= 1'b0;
`ifdef VES_STRIDE_EN
            r_stride     <= '0;
`endif
        end else begin
            r_state      <= w_state_next;
            // Registered so it stays low during reset and rises on the
            // first edge after release, and again the cycle after a run.
            r_load_ready <= (w_state_next == S_IDLE);
            r_err        <= w_load_fire && w_load_bad;

            if (w_load_fire && !w_load_bad) begin
                r_vec       <= bus.load_vec;
                r_rem       <= bus.count;
                r_out_valid <= 1'b1;
                r_out_idx   <= bus.start_idx;
                r_out_data  <= f_elem(bus.load_vec, bus.start_idx);
                r_out_last  <= (bus.count == (IDX_W+1)'(1));
`ifdef VES_STRIDE_EN
                r_stride    <= bus.stride;
`endif
            end else if (w_beat_fire) begin
                if (r_out_last) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_rem       <= '0;
                end else begin
                    r_rem      <= r_rem - (IDX_W+1)'(1);
                    r_out_idx  <= w_idx_next;
                    r_out_data <= f_elem(r_vec, w_idx_next);
                    r_out_last <= (r_rem == (IDX_W+1)'(2));
                end
            end
        end
    end

    assign bus.load_ready = r_load_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_idx    = r_out_idx;
    assign bus.out_last   = r_out_last;
    assign bus.busy       = (r_state == S_STREAM);
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vector_element_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_element_streamer
// Description : Scoreboard bench for vector_element_streamer. Stimulus pushes
//               expected beats into a queue; a monitor pops and compares on
//               each accepted output beat. Element i = 32'hA000_000i.
//               IDX_W=4 so out-of-range start_idx/count can be expressed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_element_streamer;
    localparam int N_ELEM = 8;
    localparam int NBITS  = 32;
    localparam int IDX_W  = 4;

    typedef struct packed {
        logic [31:0]      data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } beat_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic [N_ELEM*NBITS-1:0] vec;

    always #5 clk = ~clk;

    vector_element_streamer_if #(.N_ELEM(N_ELEM), .NBITS(NBITS), .IDX_W(IDX_W)) bus ();

    vector_element_streamer #(.N_ELEM(N_ELEM), .NBITS(NBITS), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got idx %0d data %h, expected no beat",
                         bus.out_idx, bus.out_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", bus.out_data, e.data);
                chk("beat_idx", 32'(bus.out_idx), 32'(e.idx));
                chk("beat_last", 32'(bus.out_last), 32'(e.last));
            end
        end
    end

    task automatic push_exp(input int idx, input bit last);
        beat_t e;
        e.data = 32'hA000_0000 + 32'(idx);
        e.idx  = IDX_W'(idx);
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Called shortly after a posedge; returns 1 time unit after the accept edge.
    task automatic do_load(input int start, input int cnt, input int strd);
        int t = 0;
        while (!bus.load_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("load_ready_before_load", 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_vec   = vec;
        bus.start_idx  = IDX_W'(start);
        bus.count      = (IDX_W+1)'(cnt);
`ifdef VES_STRIDE_EN
        bus.stride     = IDX_W'(strd);
`else
        if (strd != 1) $display("note: stride %0d ignored in this build", strd);
`endif
        @(posedge clk); #1;
        // Scramble load inputs: the running stream must not notice.
        bus.load_valid = 1'b0;
        bus.load_vec   = '1;
        bus.start_idx  = IDX_W'(5);
        bus.count      = (IDX_W+1)'(2);
    endtask

    // Wait until the scoreboard empties; check the cycle count and idle state.
    task automatic drain(input string name, input int exp_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d beats outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        if (exp_cycles > 0) chk({name, "_cycles"}, 32'(n), 32'(exp_cycles));
        chk({name, "_valid_after"}, 32'(bus.out_valid), 32'd0);
        chk({name, "_ready_after"}, 32'(bus.load_ready), 32'd1);
        chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic run(input string name, input int start, input int cnt, input int strd,
                       input int seq[8], input int exp_cycles);
        for (int i = 0; i < cnt; i++) push_exp(seq[i], i == cnt - 1);
        do_load(start, cnt, strd);
        #1;
        chk({name, "_latency_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_busy"}, 32'(bus.busy), 32'd1);
        chk({name, "_load_ready_low"}, 32'(bus.load_ready), 32'd0);
        drain(name, exp_cycles);
    endtask

    task automatic bad_load(input string name, input int start, input int cnt, input int strd);
        do_load(start, cnt, strd);
        #1;
        chk({name, "_err"}, 32'(bus.err), 32'd1);
        chk({name, "_busy"}, 32'(bus.busy), 32'd0);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        chk({name, "_err_clear"}, 32'(bus.err), 32'd0);
        chk({name, "_valid_clear"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N_ELEM; i++) vec[(N_ELEM-i)*NBITS-1 -: NBITS] = 32'hA000_0000 + 32'(i);
        bus.load_valid = 1'b0;
        bus.load_vec   = '0;
        bus.start_idx  = '0;
        bus.count      = '0;
        bus.out_ready  = 1'b0;
`ifdef VES_STRIDE_EN
        bus.stride     = '0;
`endif

        // Reset state
        #2;
        chk("rst_load_ready", 32'(bus.load_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #2 chk("release_load_ready_before_clk", 32'(bus.load_ready), 32'd0);
        @(posedge clk); #1;
        chk("release_load_ready_after_clk", 32'(bus.load_ready), 32'd1);

        bus.out_ready = 1'b1;
        // 1: full vector from 0
        run("full0", 0, 8, 1, '{0, 1, 2, 3, 4, 5, 6, 7}, 8);
        // 2: wrap past N_ELEM-1 (IDX_W=4 so a mod-16 wrap would be visible)
        run("wrap6", 6, 4, 1, '{6, 7, 0, 1, 0, 0, 0, 0}, 4);
        // full vector from 5 hits every element once
        run("full5", 5, 8, 1, '{5, 6, 7, 0, 1, 2, 3, 4}, 8);

        // 3: backpressure, out_ready 1,0,0,1,1
        push_exp(2, 1'b0);
        push_exp(3, 1'b0);
        push_exp(4, 1'b1);
        do_load(2, 3, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        #1 chk("stall_data_c1", bus.out_data, 32'hA000_0003);
        chk("stall_idx_c1", 32'(bus.out_idx), 32'd3);
        @(posedge clk); #1;
        #1 chk("stall_data_c2", bus.out_data, 32'hA000_0003);
        chk("stall_valid_c2", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        #1 chk("stall_data_c3", bus.out_data, 32'hA000_0003);
        chk("stall_last_c3", 32'(bus.out_last), 32'd0);
        drain("stall", 2);

        // 4: rejected loads
        bad_load("bad_count0", 0, 0, 1);
        bad_load("bad_start8", 8, 1, 1);
        bad_load("bad_count9", 0, 9, 1);

        // 5: reset on the second beat of a count=5 run
        for (int i = 0; i < 5; i++) push_exp(i, i == 4);
        do_load(0, 5, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_out_data", bus.out_data, 32'd0);
        chk("abort_out_idx", 32'(bus.out_idx), 32'd0);
        chk("abort_load_ready", 32'(bus.load_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run("after_abort", 4, 1, 1, '{4, 0, 0, 0, 0, 0, 0, 0}, 1);

`ifdef VES_STRIDE_EN
        // 6: stride
        run("stride3", 1, 4, 3, '{1, 4, 7, 2, 0, 0, 0, 0}, 4);
        run("stride0", 1, 3, 0, '{1, 1, 1, 0, 0, 0, 0, 0}, 3);
        bad_load("bad_stride8", 0, 1, 8);
`endif

        repeat (2) @(posedge clk);
        #1 chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
